// File: rtl/key_press_tracker.sv
// Debounced press/release tracking of one scanned key at a time, with
// long-press detection and auto-repeat ticks, presented as six state nibbles.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | no key tracked, active_code = F
// PRESS_DB   | candidate key latched, counting consecutive matching samples
// PRESSED    | press accepted (nibble 1), counting hold time
// LONG       | long-held (nibble 2), emitting one-cycle repeat ticks (3)
// RELEASE_DB | counting consecutive non-matches, returns to ret_q on match
module key_press_tracker #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 100_000_000,
    parameter int REPEAT_CYCLES   = 20_000_000,
    parameter int CNT_W           = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] key_code,
    input  logic       key_vaild,
    output logic [3:0] key0_state,
    output logic [3:0] key1_state,
    output logic [3:0] key2_state,
    output logic [3:0] key3_state,
    output logic [3:0] key4_state,
    output logic [3:0] key5_state,
    output logic [3:0] active_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS_DB,
        S_PRESSED,
        S_LONG,
        S_RELEASE_DB
    } state_t;

    localparam logic [CNT_W-1:0] DEB_C  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] REP_C  = CNT_W'(REPEAT_CYCLES);
    localparam logic [3:0]       NO_KEY = 4'hF;

    state_t           state_q, state_nxt;
    state_t           ret_q, ret_nxt;
    state_t           cur;
    logic [3:0]       code_q, code_nxt;
    logic [3:0]       val_q, val_nxt;
    logic [CNT_W-1:0] deb_q, deb_nxt;
    logic [CNT_W-1:0] hold_q, hold_nxt;
    logic [CNT_W-1:0] rep_q, rep_nxt;
    logic [CNT_W-1:0] deb_inc, hold_inc, rep_inc;
    logic             match;
    logic [3:0]       key_q [6];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_nxt = state_q;
        ret_nxt   = ret_q;
        code_nxt  = code_q;
        val_nxt   = val_q;
        deb_nxt   = deb_q;
        hold_nxt  = hold_q;
        rep_nxt   = rep_q;

        match    = key_vaild && (key_code == code_q);
        deb_inc  = sat_inc(deb_q);
        hold_inc = sat_inc(hold_q);
        rep_inc  = sat_inc(rep_q);

        // A match during release debounce is handled exactly as a match in
        // the state we came from, so the returning sample counts toward hold.
        cur = state_q;
        if (state_q == S_RELEASE_DB && match) begin
            cur = ret_q;
        end

        case (cur)
            S_IDLE: begin
                val_nxt  = 4'd0;
                code_nxt = NO_KEY;
                deb_nxt  = '0;
                hold_nxt = '0;
                rep_nxt  = '0;
                if (key_vaild && key_code < 4'd6) begin
                    code_nxt = key_code;
                    if (DEBOUNCE_CYCLES <= 1) begin
                        state_nxt = S_PRESSED;
                        val_nxt   = 4'd1;
                    end else begin
                        state_nxt = S_PRESS_DB;
                        deb_nxt   = CNT_W'(1);
                    end
                end
            end

            S_PRESS_DB: begin
                if (match) begin
                    deb_nxt = deb_inc;
                    if (deb_inc >= DEB_C) begin
                        state_nxt = S_PRESSED;
                        val_nxt   = 4'd1;
                        hold_nxt  = '0;
                        deb_nxt   = '0;
                    end
                end else begin
                    state_nxt = S_IDLE;
                    code_nxt  = NO_KEY;
                    val_nxt   = 4'd0;
                    deb_nxt   = '0;
                end
            end

            S_PRESSED: begin
                if (match) begin
                    state_nxt = S_PRESSED;
                    deb_nxt   = '0;
                    val_nxt   = 4'd1;
                    hold_nxt  = hold_inc;
                    if (hold_inc >= LONG_C) begin
                        state_nxt = S_LONG;
                        val_nxt   = 4'd2;
                        rep_nxt   = '0;
                    end
                end else if (DEBOUNCE_CYCLES <= 1) begin
                    state_nxt = S_IDLE;
                    code_nxt  = NO_KEY;
                    val_nxt   = 4'd0;
                    deb_nxt   = '0;
                end else begin
                    state_nxt = S_RELEASE_DB;
                    ret_nxt   = S_PRESSED;
                    deb_nxt   = CNT_W'(1);
                end
            end

            S_LONG: begin
                if (match) begin
                    state_nxt = S_LONG;
                    deb_nxt   = '0;
                    val_nxt   = 4'd2;
                    rep_nxt   = rep_inc;
                    if (rep_inc >= REP_C) begin
                        val_nxt = 4'd3;
                        rep_nxt = '0;
                    end
                end else if (DEBOUNCE_CYCLES <= 1) begin
                    state_nxt = S_IDLE;
                    code_nxt  = NO_KEY;
                    val_nxt   = 4'd0;
                    deb_nxt   = '0;
                end else begin
                    state_nxt = S_RELEASE_DB;
                    ret_nxt   = S_LONG;
                    val_nxt   = 4'd2;
                    deb_nxt   = CNT_W'(1);
                end
            end

            S_RELEASE_DB: begin
                deb_nxt = deb_inc;
                if (deb_inc >= DEB_C) begin
                    state_nxt = S_IDLE;
                    code_nxt  = NO_KEY;
                    val_nxt   = 4'd0;
                    deb_nxt   = '0;
                end
            end

            default: begin
                state_nxt = S_IDLE;
                code_nxt  = NO_KEY;
                val_nxt   = 4'd0;
                deb_nxt   = '0;
                hold_nxt  = '0;
                rep_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ret_q   <= S_PRESSED;
            code_q  <= NO_KEY;
            val_q   <= 4'd0;
            deb_q   <= '0;
            hold_q  <= '0;
            rep_q   <= '0;
            for (int i = 0; i < 6; i++) begin
                key_q[i] <= 4'd0;
            end
        end else begin
            state_q <= state_nxt;
            ret_q   <= ret_nxt;
            code_q  <= code_nxt;
            val_q   <= val_nxt;
            deb_q   <= deb_nxt;
            hold_q  <= hold_nxt;
            rep_q   <= rep_nxt;
            for (int i = 0; i < 6; i++) begin
                key_q[i] <= (code_nxt == 4'(i)) ? val_nxt : 4'd0;
            end
        end
    end

    assign key0_state  = key_q[0];
    assign key1_state  = key_q[1];
    assign key2_state  = key_q[2];
    assign key3_state  = key_q[3];
    assign key4_state  = key_q[4];
    assign key5_state  = key_q[5];
    assign active_code = code_q;

endmodule

// File: tb/tb_key_press_tracker.sv
// Directed bench for key_press_tracker: an abstract per-edge model checked
// every cycle, plus literal expectations at the hand-computed edges.
module tb_key_press_tracker;

    localparam int DEB = 4;
    localparam int LNG = 20;
    localparam int REP = 5;

    logic       clk;
    logic       reset_n;
    logic [3:0] key_code;
    logic       key_vaild;
    logic [3:0] key0_state, key1_state, key2_state, key3_state, key4_state, key5_state;
    logic [3:0] active_code;
    logic [3:0] ks [6];

    int errors = 0;
    int checks = 0;
    int t_edge = 0;

    // model: tracked key, whether accepted, level 1/2, counters, release flag
    int m_t = -1;
    bit m_conf = 0;
    int m_lvl = 0;
    int m_deb = 0;
    int m_hold = 0;
    int m_rep = 0;
    bit m_rel = 0;
    bit m_tick = 0;

    key_press_tracker #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES(LNG),
        .REPEAT_CYCLES(REP),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .key_code(key_code),
        .key_vaild(key_vaild),
        .key0_state(key0_state),
        .key1_state(key1_state),
        .key2_state(key2_state),
        .key3_state(key3_state),
        .key4_state(key4_state),
        .key5_state(key5_state),
        .active_code(active_code)
    );

    always_comb begin
        ks[0] = key0_state;
        ks[1] = key1_state;
        ks[2] = key2_state;
        ks[3] = key3_state;
        ks[4] = key4_state;
        ks[5] = key5_state;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic release_key();
        m_t = -1; m_conf = 0; m_lvl = 0; m_rel = 0; m_deb = 0;
    endtask

    task automatic held_sample();
        if (m_lvl == 1) begin
            m_hold++;
            if (m_hold >= LNG) begin m_lvl = 2; m_rep = 0; end
        end else begin
            m_rep++;
            if (m_rep >= REP) begin m_tick = 1; m_rep = 0; end
        end
    endtask

    task automatic model_step(input bit r, input bit v, input int c);
        bit match;
        match = v && (m_t >= 0) && (c == m_t);
        m_tick = 0;
        if (!r) begin
            release_key();
            m_hold = 0; m_rep = 0;
        end else if (m_t < 0) begin
            if (v && c < 6) begin
                m_t = c;
                if (DEB == 1) begin m_conf = 1; m_lvl = 1; m_hold = 0; end
                else m_deb = 1;
            end
        end else if (!m_conf) begin
            if (match) begin
                m_deb++;
                if (m_deb >= DEB) begin m_conf = 1; m_lvl = 1; m_hold = 0; end
            end else release_key();
        end else if (m_rel) begin
            if (match) begin m_rel = 0; held_sample(); end
            else begin
                m_deb++;
                if (m_deb >= DEB) release_key();
            end
        end else begin
            if (match) held_sample();
            else if (DEB == 1) release_key();
            else begin m_rel = 1; m_deb = 1; end
        end
    endtask

    task automatic compare();
        int e;
        for (int k = 0; k < 6; k++) begin
            e = (m_t == k && m_conf) ? (m_tick ? 3 : m_lvl) : 0;
            chk($sformatf("model key%0d edge %0d", k, t_edge), int'(ks[k]), e);
        end
        chk($sformatf("model active_code edge %0d", t_edge), int'(active_code),
            (m_t < 0) ? 15 : m_t);
    endtask

    task automatic step(input bit r, input bit v, input int c);
        reset_n   = r;
        key_vaild = v;
        key_code  = 4'(c);
        @(posedge clk);
        #1;
        model_step(r, v, c);
        compare();
        t_edge++;
    endtask

    task automatic run(input int n, input bit r, input bit v, input int c);
        for (int i = 0; i < n; i++) step(r, v, c);
    endtask

    task automatic all_zero(input string name);
        for (int k = 0; k < 6; k++) chk($sformatf("%s key%0d", name, k), int'(ks[k]), 0);
    endtask

    initial begin
        reset_n = 1'b0; key_vaild = 1'b0; key_code = 4'd0;
        run(2, 0, 0, 0);
        all_zero("reset");
        chk("reset active_code", int'(active_code), 15);
        run(2, 1, 0, 0);

        // valid press of key 2, release at edge 10
        t_edge = 0;
        run(3, 1, 1, 2);
        chk("press key2 edge2", int'(key2_state), 0);
        run(1, 1, 1, 2);
        chk("press key2 edge3", int'(key2_state), 1);
        chk("press active edge3", int'(active_code), 2);
        run(6, 1, 1, 2);
        run(3, 1, 0, 0);
        chk("release key2 edge12", int'(key2_state), 1);
        run(1, 1, 0, 0);
        chk("release key2 edge13", int'(key2_state), 0);
        chk("release active edge13", int'(active_code), 15);
        run(2, 1, 0, 0);

        // press bounce then clean hold of key 1
        t_edge = 0;
        run(3, 1, 1, 1);
        run(1, 1, 0, 0);
        chk("bounce key1", int'(key1_state), 0);
        chk("bounce active", int'(active_code), 15);
        run(3, 1, 1, 1);
        chk("clean key1 3rd", int'(key1_state), 0);
        run(1, 1, 1, 1);
        chk("clean key1 4th", int'(key1_state), 1);
        run(4, 1, 0, 0);
        chk("clean key1 released", int'(key1_state), 0);

        // different code during press debounce restarts via IDLE
        run(2, 1, 1, 1);
        run(1, 1, 1, 2);
        chk("switch in debounce active", int'(active_code), 15);
        run(3, 1, 1, 2);
        chk("switch key2 3rd", int'(key2_state), 0);
        run(1, 1, 1, 2);
        chk("switch key2 4th", int'(key2_state), 1);
        run(5, 1, 0, 0);

        // long hold with repeat on key 5
        t_edge = 0;
        run(4, 1, 1, 5);
        chk("long key5 edge3", int'(key5_state), 1);
        run(19, 1, 1, 5);
        chk("long key5 edge22", int'(key5_state), 1);
        run(1, 1, 1, 5);
        chk("long key5 edge23", int'(key5_state), 2);
        run(4, 1, 1, 5);
        chk("long key5 edge27", int'(key5_state), 2);
        run(1, 1, 1, 5);
        chk("tick key5 edge28", int'(key5_state), 3);
        run(1, 1, 1, 5);
        chk("tick key5 edge29", int'(key5_state), 2);
        run(4, 1, 1, 5);
        chk("tick key5 edge33", int'(key5_state), 3);
        run(25, 1, 1, 5);
        chk("tick key5 edge58", int'(key5_state), 3);
        run(1, 1, 1, 5);
        run(3, 1, 0, 0);
        chk("long release key5 edge62", int'(key5_state), 2);
        run(1, 1, 0, 0);
        chk("long release key5 edge63", int'(key5_state), 0);
        run(2, 1, 0, 0);

        // release glitch during PRESSED delays long entry by two edges
        t_edge = 0;
        run(10, 1, 1, 4);
        run(2, 1, 0, 0);
        chk("glitch key4 held", int'(key4_state), 1);
        run(13, 1, 1, 4);
        chk("glitch key4 edge24", int'(key4_state), 1);
        run(1, 1, 1, 4);
        chk("glitch key4 edge25", int'(key4_state), 2);
        run(5, 1, 0, 0);

        // code switch 3 -> 0 while pressed
        t_edge = 0;
        run(10, 1, 1, 3);
        run(3, 1, 1, 0);
        chk("switch key3 edge12", int'(key3_state), 1);
        run(1, 1, 1, 0);
        chk("switch key3 edge13", int'(key3_state), 0);
        chk("switch active edge13", int'(active_code), 15);
        run(3, 1, 1, 0);
        chk("switch key0 edge16", int'(key0_state), 0);
        chk("switch active edge16", int'(active_code), 0);
        run(1, 1, 1, 0);
        chk("switch key0 edge17", int'(key0_state), 1);
        run(5, 1, 0, 0);

        // invalid codes never start tracking
        run(8, 1, 1, 9);
        all_zero("code9");
        chk("code9 active", int'(active_code), 15);
        run(5, 1, 1, 6);
        chk("code6 active", int'(active_code), 15);
        run(2, 1, 0, 0);

        // reset while a tick is showing
        t_edge = 0;
        run(29, 1, 1, 5);
        chk("pre-reset tick", int'(key5_state), 3);
        run(1, 0, 1, 5);
        all_zero("mid reset");
        chk("mid reset active", int'(active_code), 15);
        run(3, 1, 1, 5);
        chk("post reset key5 3rd", int'(key5_state), 0);
        chk("post reset active", int'(active_code), 5);
        run(1, 1, 1, 5);
        chk("post reset key5 4th", int'(key5_state), 1);
        run(5, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
